// File: rtl/fdu_pkg.sv
// Shared field positions, instruction-type codes, FSM states and the decoded
// instruction payload for the fetch/decode front end.
package fdu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IMM_W   = 21;

  localparam logic [1:0] TYPE_ILL = 2'b00;
  localparam logic [1:0] TYPE_A   = 2'b01;
  localparam logic [1:0] TYPE_B   = 2'b10;
  localparam logic [1:0] TYPE_C   = 2'b11;

  localparam logic [2:0] HALT_FUNC = 3'b000;
  localparam logic [2:0] HALT_OPC  = 3'b111;

  localparam int unsigned FUNC_MSB   = 31;
  localparam int unsigned FUNC_LSB   = 29;
  localparam int unsigned TYPE_MSB   = 28;
  localparam int unsigned TYPE_LSB   = 27;
  localparam int unsigned OPC_MSB    = 26;
  localparam int unsigned OPC_LSB    = 24;
  localparam int unsigned RD_MSB     = 23;
  localparam int unsigned RD_LSB     = 20;
  localparam int unsigned R1_MSB     = 19;
  localparam int unsigned R1_LSB     = 16;
  localparam int unsigned HAS_IMM_BIT = 15;
  localparam int unsigned R2_MSB     = 14;
  localparam int unsigned R2_LSB     = 11;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  typedef struct packed {
    logic [2:0]       func;
    logic [1:0]       typ;
    logic [2:0]       opcode;
    logic [3:0]       rd;
    logic [3:0]       r1;
    logic [3:0]       r2;
    logic             has_imm;
    logic [IMM_W-1:0] imm;
    logic             illegal;
  } dec_t;

endpackage

// File: rtl/fetch_decode_unit_imm_extract.sv
// Type-dependent immediate extraction and extension; type 00 yields a zero
// immediate and flags the word as illegal.
module imm_extract
  import fdu_pkg::*;
#(
  parameter bit IMM_SEXT = 1'b1
) (
  input  logic [IMM_W-1:0] instr_i,
  input  logic [1:0]       type_i,
  output logic [IMM_W-1:0] imm_c_o,
  output logic             illegal_c_o
);

  always_comb begin
    imm_c_o     = '0;
    illegal_c_o = 1'b0;
    case (type_i)
      TYPE_A: imm_c_o = IMM_SEXT ? {{6{instr_i[14]}}, instr_i[14:0]}
                                 : {6'b0, instr_i[14:0]};
      TYPE_B: imm_c_o = IMM_SEXT ? {{10{instr_i[10]}}, instr_i[10:0]}
                                 : {10'b0, instr_i[10:0]};
      TYPE_C: imm_c_o = instr_i;
      default: illegal_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end: owns the PC, latches one decoded instruction per
// accepted fetch, and handles branch redirects, stalls and halt/resume.
module fetch_decode_unit
  import fdu_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter bit              IMM_SEXT = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               instr_valid_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               branch_taken_i,
  input  logic [IMM_W-1:0]   branch_offset_i,
  input  logic               resume_i,
  output logic [PC_W-1:0]    pc_o,
  output logic               dec_valid_o,
  output logic [PC_W-1:0]    dec_pc_o,
  output logic [2:0]         dec_func_o,
  output logic [1:0]         dec_type_o,
  output logic [2:0]         dec_opcode_o,
  output logic [3:0]         dec_rd_o,
  output logic [3:0]         dec_r1_o,
  output logic [3:0]         dec_r2_o,
  output logic [0:0]         dec_has_imm_o,
  output logic [IMM_W-1:0]   dec_imm_o,
  output logic               dec_illegal_o,
  output logic               halted_o
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] dec_pc_q, dec_pc_d;
  logic            dec_valid_q, dec_valid_d;
  dec_t            dec_q, dec_d;

  logic [IMM_W-1:0] imm_c;
  logic             illegal_c;
  logic             is_halt_c;
  logic [31:0]      offset_sext_c;
  logic [PC_W-1:0]  branch_target_c;

  imm_extract #(.IMM_SEXT(IMM_SEXT)) u_imm_extract (
    .instr_i     (instr_i[IMM_W-1:0]),
    .type_i      (instr_i[TYPE_MSB:TYPE_LSB]),
    .imm_c_o     (imm_c),
    .illegal_c_o (illegal_c)
  );

  assign is_halt_c       = (instr_i[FUNC_MSB:FUNC_LSB] == HALT_FUNC) &&
                           (instr_i[OPC_MSB:OPC_LSB] == HALT_OPC);
  // Offset is widened to 32 bits first, then truncated to the PC width.
  assign offset_sext_c   = {{(32 - IMM_W){branch_offset_i[IMM_W-1]}}, branch_offset_i};
  assign branch_target_c = dec_pc_q + PC_W'(offset_sext_c);

  // Next-state: branch beats accept/halt in RUN; HALTED only listens to resume.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    dec_pc_d    = dec_pc_q;
    dec_d       = dec_q;
    dec_valid_d = 1'b0;
    if (en_i) begin
      case (state_q)
        ST_RUN: begin
          if (branch_taken_i) begin
            pc_d = branch_target_c;
          end else if (instr_valid_i) begin
            dec_valid_d   = 1'b1;
            dec_pc_d      = pc_q;
            dec_d.func    = instr_i[FUNC_MSB:FUNC_LSB];
            dec_d.typ     = instr_i[TYPE_MSB:TYPE_LSB];
            dec_d.opcode  = instr_i[OPC_MSB:OPC_LSB];
            dec_d.rd      = instr_i[RD_MSB:RD_LSB];
            dec_d.r1      = instr_i[R1_MSB:R1_LSB];
            dec_d.r2      = instr_i[R2_MSB:R2_LSB];
            dec_d.has_imm = instr_i[HAS_IMM_BIT];
            dec_d.imm     = imm_c;
            dec_d.illegal = illegal_c;
            if (is_halt_c) state_d = ST_HALTED;
            else           pc_d    = pc_q + PC_W'(1);
          end
        end
        ST_HALTED: begin
          if (resume_i) begin
            state_d = ST_RUN;
            pc_d    = pc_q + PC_W'(1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      dec_pc_q    <= '0;
      dec_valid_q <= 1'b0;
      dec_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dec_pc_q    <= dec_pc_d;
      dec_valid_q <= dec_valid_d;
      dec_q       <= dec_d;
    end
  end

  assign pc_o          = pc_q;
  assign dec_valid_o   = dec_valid_q;
  assign dec_pc_o      = dec_pc_q;
  assign dec_func_o    = dec_q.func;
  assign dec_type_o    = dec_q.typ;
  assign dec_opcode_o  = dec_q.opcode;
  assign dec_rd_o      = dec_q.rd;
  assign dec_r1_o      = dec_q.r1;
  assign dec_r2_o      = dec_q.r2;
  assign dec_has_imm_o = dec_q.has_imm;
  assign dec_imm_o     = dec_q.imm;
  assign dec_illegal_o = dec_q.illegal;
  assign halted_o      = (state_q == ST_HALTED);

endmodule

// File: doc/fetch_decode_unit.md
# fetch_decode_unit

Registered fetch/decode front end for the 32-bit simple CPU. It owns the program counter and latches one decoded instruction per accepted fetch. It also handles PC-relative branches, stalls, halt/resume and illegal-type detection. It sits between instruction memory (driven by `pc`) and the register-file/ALU stage (consumes `dec_*`), and is parametrised in PC width, reset vector and immediate extension mode.

## Interface
- `PC_W`, 32: program counter width (16..32).
- `RESET_PC`, 0: PC value loaded on reset.
- `IMM_SEXT`, 1: 1 = sign-extend immediates to 21 bits; 0 = zero-extend.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  advance enable; 0 = stall (all state holds).
- `instr_valid`  in  1  `instr` holds the word at `pc` this cycle.
- `instr`  in  32  instruction word.
- `branch_taken`  in  1  execute stage redirects the PC this cycle.
- `branch_offset`  in  21  signed word offset, relative to `dec_pc`.
- `resume`  in  1  leave HALTED.
- `pc`  out  PC_W  fetch address.
- `dec_valid`  out  1  `dec_*` hold a newly decoded instruction (one-cycle pulse per accept).
- `dec_pc`  out  PC_W  address of the decoded instruction.
- `dec_func` [2:0], `dec_type` [1:0], `dec_opcode` [2:0], `dec_rd` [3:0], `dec_r1` [3:0], `dec_r2` [3:0], `dec_has_imm` [0:0], `dec_imm` [20:0]  out  decoded fields.
- `dec_illegal`  out  1  decoded `type` == 2'b00.
- `halted`  out  1  FSM is in HALTED.

## Operation
- Field map: func[31:29], type[28:27], opcode[26:24], rd[23:20], r1[19:16], has_imm[15], r2[14:11].
- Immediate by type:
  - 01 (A): instr[14:0].
  - 10 (B): instr[10:0].
  - 11 (C): instr[20:0].
  - 00: imm = 0 and `dec_illegal` = 1.
- Immediate extension: A and B are extended to 21 bits from their top bit when `IMM_SEXT`=1, with zeros otherwise. C is used as-is.
- Halt instruction: func == 3'b000 and opcode == 3'b111. It is detected in every type.
- FSM states:
  - RUN:
    - Accept when `en` && `instr_valid`: capture all fields, set `dec_pc` = `pc`, pulse `dec_valid`.
    - If the captured word is halt: go to HALTED and leave `pc` unchanged.
    - Otherwise: `pc` <= `pc` + 1.
  - HALTED:
    - `instr_valid` is ignored and `dec_valid` = 0.
    - `resume` && `en`: go to RUN and set `pc` <= `pc` + 1.
- Branch:
  - `branch_taken` && `en` in RUN: `pc` <= `dec_pc` + sext(`branch_offset`). The same cycle's accept is squashed (`dec_valid` = 0).
  - Branch has priority over sequential increment and over a halt in the same cycle.
  - Branch in HALTED is ignored.
- Arithmetic: modulo 2^PC_W. The offset is sign-extended (or truncated) to PC_W. `pc` wraps from all-ones to 0 silently.
- `en` = 0: `pc`, state and `dec_*` hold, and `dec_valid` drops to 0.
- `dec_*` fields other than `dec_valid` hold their last captured value until the next accept.

## Timing
- Reset (synchronous): `pc` = `RESET_PC`, state RUN, `dec_valid` = 0, `halted` = 0, every `dec_*` field = 0, `dec_illegal` = 0.
- `rst` has priority over every input, including mid-halt and mid-branch.
- Decode latency: 1 cycle. Accept at edge N gives `dec_*` valid after edge N.
- `pc` updates on the same edge as the accept, so the next fetch address is available 1 cycle after accept.
- `halted` asserts the cycle after the halt is accepted and deasserts the cycle after `resume`.
- `resume` asserted while in RUN: ignored.

## Structure
- Package `fdu_pkg` holds:
  - Type localparams `TYPE_A/B/C`, `TYPE_ILL`.
  - `HALT_FUNC`, `HALT_OPC`.
  - Field bit-position localparams.
  - State enum {RUN, HALTED}.
- One combinational sub-module, `imm_extract`, maps (instr, type, `IMM_SEXT`) to a 21-bit imm plus the illegal flag.
- PC register, FSM and output registers live in the top module.

## Test plan
- Reset, then instr 0x2A_12_34_56 valid with `en`=1 at `pc`=0:
  - Next cycle: `dec_valid`=1, func=1, type=01, opcode=2, rd=1, r1=2, has_imm=0, r2=6, imm (sext of 0x3456) = 0x003456.
  - `pc`=1.
- Type B word with instr[10:0]=0x7FF, `IMM_SEXT`=1 → `dec_imm`=0x1FFFFF. With `IMM_SEXT`=0 → 0x0007FF.
- Branch: at `dec_pc`=5, `branch_taken`=1, offset=−3 (0x1FFFFD) → `pc`=2 next cycle and `dec_valid`=0 that cycle.
- Halt word 0x07000000 at `pc`=9:
  - `halted`=1 and `pc` stays 9 for 10 cycles despite `instr_valid`.
  - `resume` → `halted`=0 and `pc`=10.
- `PC_W`=16, `pc`=0xFFFF, accept → `pc`=0x0000.
- Stall and reset:
  - `en`=0 for 3 cycles mid-stream → `pc` and `dec_*` frozen, `dec_valid`=0.
  - `rst` while HALTED → `pc`=`RESET_PC`, `halted`=0.
